tribuf_bus_arb: RTL and testbench



---
 rtl/tribuf_bus_arb_pkg.sv | 17 +
 rtl/tribuf_bus_arb_if.sv | 34 +++
 rtl/tribuf_bus_arb_rr_pick.sv | 34 +++
 rtl/tribuf_bus_arb.sv | 141 ++++++++++++++
 tb/tb_tribuf_bus_arb.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/tribuf_bus_arb_pkg.sv
// tribuf_pkg: shared types and helpers for the tristate bus arbiter slice.
//   arb_state_t : arbiter FSM state encoding
//   idx_w()     : width of a channel index for a given channel count
package tribuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  // Always at least one bit wide so a 1-channel build still has a legal index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tribuf_bus_arb_if.sv
// tribuf_bus_arb_if: channel-side bundle of the tristate bus arbiter.
//   req       : per-channel level request         (master -> slave)
//   data_in   : packed channel data, ch i at [i*WIDTH +: WIDTH]
//   gnt       : registered one-hot grant          (slave -> master)
//   bus_oe    : arbiter is driving the shared bus
//   cap_data  : registered sample of the shared bus
//   cap_valid : cap_data came from an owned cycle
//   cap_src   : channel index of the cap_data sample
// The tristate bus itself stays a plain inout on the arbiter so the
// pad-side net is never routed through an interface.
interface tribuf_bus_arb_if
  import tribuf_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) ();

  localparam int IDX_W = idx_w(N_CH);

  logic [N_CH-1:0]       req;
  logic [N_CH*WIDTH-1:0] data_in;
  logic [N_CH-1:0]       gnt;
  logic                  bus_oe;
  logic [WIDTH-1:0]      cap_data;
  logic                  cap_valid;
  logic [IDX_W-1:0]      cap_src;

  modport master (output req, data_in,
                  input  gnt, bus_oe, cap_data, cap_valid, cap_src);

  modport slave  (input  req, data_in,
                  output gnt, bus_oe, cap_data, cap_valid, cap_src);

endinterface

// File: rtl/tribuf_bus_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request vector
//   rr_ptr : index of the last winner; search starts at rr_ptr+1
//   found  : at least one request present
//   idx    : winning channel index (0 when found is low)
module rr_pick
  import tribuf_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]           req,
  input  logic [idx_w(N_CH)-1:0]    rr_ptr,
  output logic                      found,
  output logic [idx_w(N_CH)-1:0]    idx
);

  localparam int IDX_W = idx_w(N_CH);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_CH);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tribuf_bus_arb.sv
// tribuf_bus_arb: round-robin owner of a shared tristate bus with a
// mandatory one-cycle turnaround between owners, plus a registered capture
// of the resolved bus value tagged with its source channel.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bif   : channel bundle (req, data_in, gnt, bus_oe, cap_*)
//   bus   : shared tristate bus
// Build option TRIBUF_ARB_PARK_EN: park the bus on data_in[rr_ptr] outside
// OWN instead of releasing it to Z.
//
// state | meaning
// IDLE  | no owner, waiting for any request
// OWN   | owner drives the bus, beat counts owned cycles
// TURN  | one undriven/parked cycle between owners
module tribuf_bus_arb
  import tribuf_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tribuf_bus_arb_if.slave  bif,
  inout  wire [WIDTH-1:0]  bus
);

  localparam int IDX_W = idx_w(N_CH);
  localparam int BW    = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [N_CH-1:0]  gnt_q, gnt_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] cap_data_q;
  logic             cap_valid_q;
  logic [IDX_W-1:0] cap_src_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] ch_data [N_CH];
  logic [IDX_W-1:0] drv_sel;
  logic [WIDTH-1:0] bus_drv;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign ch_data[g] = bif.data_in[g*WIDTH +: WIDTH];
  end

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req    (bif.req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      OWN: begin
        if (!bif.req[owner_q] || beat_q == BW'(MAX_BURST)) begin
          state_d  = TURN;
          rr_ptr_d = owner_q;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      // IDLE and TURN arbitrate identically; TURN already sees the updated rr_ptr.
      default: begin
        if (pick_found) begin
          state_d = OWN;
          owner_d = pick_idx;
          beat_d  = BW'(1);
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // Grant and enable are registered from the next state so they line up
    // with the cycle the new owner actually holds the bus.
    gnt_d = '0;
    if (state_d == OWN) gnt_d[owner_d] = 1'b1;
`ifdef TRIBUF_ARB_PARK_EN
    oe_d = 1'b1;
`else
    oe_d = (state_d == OWN);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IDX_W'(N_CH - 1);
      beat_q   <= '0;
      gnt_q    <= '0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
      oe_q     <= oe_d;
    end
  end

`ifdef TRIBUF_ARB_PARK_EN
  assign drv_sel = (state_q == OWN) ? owner_q : rr_ptr_q;
`else
  assign drv_sel = owner_q;
`endif
  assign bus_drv = ch_data[drv_sel];
  assign bus     = oe_q ? bus_drv : {WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_src_q   <= '0;
    end else if (state_q == OWN) begin
      cap_data_q  <= bus;
      cap_valid_q <= 1'b1;
      cap_src_q   <= owner_q;
    end else begin
      cap_valid_q <= 1'b0;
    end
  end

  assign bif.gnt       = gnt_q;
  assign bif.bus_oe    = oe_q;
  assign bif.cap_data  = cap_data_q;
  assign bif.cap_valid = cap_valid_q;
  assign bif.cap_src   = cap_src_q;

endmodule

// File: tb/tb_tribuf_bus_arb.sv
// tb_tribuf_bus_arb: randomized and directed stimulus against a cycle-level
// reference model of the round-robin tristate bus arbiter.
module tb_tribuf_bus_arb;

  localparam int N_CH      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [WIDTH-1:0] bus;

  tribuf_bus_arb_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bif ();

  tribuf_bus_arb #(.N_CH(N_CH), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [N_CH-1:0]  req_v;
  logic [WIDTH-1:0] dat [N_CH];

  // Reference model: who owns the bus this cycle (-1 = nobody) and how many
  // cycles of the burst are used; a released bus always spends one cycle
  // ownerless before anyone can be picked again.
  int m_own, m_beat, m_ptr, m_csrc;
  logic [WIDTH-1:0] m_cdata;
  bit m_cvalid, m_live;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic apply();
    bif.req = req_v;
    for (int i = 0; i < N_CH; i++) bif.data_in[i*WIDTH +: WIDTH] = dat[i];
  endtask

  task automatic model_reset();
    m_own = -1; m_beat = 0; m_ptr = N_CH - 1;
    m_cdata = '0; m_cvalid = 0; m_csrc = 0; m_live = 0;
  endtask

  task automatic model_edge();
    if (m_own >= 0) begin
      m_cvalid = 1; m_cdata = dat[m_own]; m_csrc = m_own;
    end else begin
      m_cvalid = 0;
    end
    if (m_own >= 0) begin
      if (!req_v[m_own] || m_beat == MAX_BURST) begin
        m_ptr = m_own;
        m_own = -1;
      end else begin
        m_beat++;
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (m_ptr + k) % N_CH;
        if (req_v[c]) begin
          m_own = c; m_beat = 1;
          break;
        end
      end
    end
    m_live = 1;
  endtask

  task automatic check_all();
    logic [31:0] exp_gnt;
    bit exp_oe;
    logic [WIDTH-1:0] exp_bus;
    exp_gnt = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
`ifdef TRIBUF_ARB_PARK_EN
    exp_oe  = m_live;
    exp_bus = dat[(m_own >= 0) ? m_own : m_ptr];
`else
    exp_oe  = (m_own >= 0);
    exp_bus = dat[(m_own >= 0) ? m_own : 0];
`endif
    check_eq("gnt", 32'(bif.gnt), exp_gnt);
    check_eq("gnt_onehot", 32'($countones(bif.gnt) <= 1), 32'd1);
    check_eq("bus_oe", 32'(bif.bus_oe), 32'(exp_oe));
    if (exp_oe) check_eq("bus", 32'(bus), 32'(exp_bus));
    check_eq("cap_valid", 32'(bif.cap_valid), 32'(m_cvalid));
    check_eq("cap_data", 32'(bif.cap_data), 32'(m_cdata));
    check_eq("cap_src", 32'(bif.cap_src), 32'(m_csrc));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  int own_log[$];
  logic [N_CH-1:0] prev_gnt;
  int gnt0_cnt;
  bit got;

  initial begin
    req_v = '0;
    for (int i = 0; i < N_CH; i++) dat[i] = 8'h10 + 8'(i);
    apply();
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state, then a single sole requester.
    do_reset();
    dat[0] = 8'hA5; req_v = 4'b0001; apply();
    gnt0_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bif.gnt == 4'b0001) gnt0_cnt++;
    end
    check_eq("burst_len", 32'(gnt0_cnt), 32'(MAX_BURST));
    check_eq("burst_turn_gnt", 32'(bif.gnt), 32'd0);
    step();
    check_eq("regrant", 32'(bif.gnt), 32'b0001);
    check_eq("cap_a5", 32'(bif.cap_data), 32'hA5);
    repeat (6) step();

    // Round-robin order with everyone requesting from reset.
    do_reset();
    req_v = 4'b1111; apply();
    prev_gnt = '0;
    for (int i = 0; i < 26; i++) begin
      step();
      if (bif.gnt != 0 && bif.gnt != prev_gnt)
        for (int c = 0; c < N_CH; c++) if (bif.gnt[c]) own_log.push_back(c);
      prev_gnt = bif.gnt;
    end
    check_eq("rr_count", 32'(own_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < own_log.size(); k++)
      check_eq("rr_order", 32'(own_log[k]), 32'(k % N_CH));

    // Early release by ch2 with ch1 waiting.
    req_v = '0; apply();
    repeat (3) step();
    req_v = 4'b0100; apply();
    repeat (2) step();
    check_eq("early_own2", 32'(bif.gnt), 32'b0100);
    req_v = 4'b0010; apply();
    step();
    check_eq("early_turn", 32'(bif.gnt), 32'd0);
    step();
    check_eq("early_gnt1", 32'(bif.gnt), 32'b0010);

    // Randomized requests and data.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req_v = 4'($urandom_range(0, 15));
      for (int c = 0; c < N_CH; c++) dat[c] = 8'($urandom);
      apply();
      step();
    end

    // Asynchronous reset in the middle of an owned burst.
    req_v = 4'b1111; apply();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (bif.gnt != 0) got = 1;
    end
    check_eq("mid_own_reached", 32'(got), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_gnt", 32'(bif.gnt), 32'd0);
    check_eq("async_oe", 32'(bif.bus_oe), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_reset_ch0", 32'(bif.gnt), 32'b0001);
    repeat (4) step();

`ifdef TRIBUF_ARB_PARK_EN
    do_reset();
    dat[3] = 8'h3C; req_v = 4'b1000; apply();
    repeat (3) step();
    req_v = '0; apply();
    repeat (4) step();
    check_eq("park_bus", 32'(bus), 32'h3C);
    check_eq("park_oe", 32'(bif.bus_oe), 32'd1);
    check_eq("park_cap_valid", 32'(bif.cap_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
